bra_predictor_gshare: RTL and testbench

- Parametrised global-history branch predictor with a configurable counter width, history length and index hash (concatenate or XOR).
- Sits between Decoder and ROB. The Decoder gets a same-cycle taken/not-taken prediction plus the history snapshot used to make it.
- The ROB returns that snapshot at resolution, so training hits exactly the entry that was predicted.
- Global history is updated speculatively at predict time and repaired on mispredict. The table is cleared by a sequential init walk after reset.

---
 rtl/bra_predictor_gshare_pkg.sv | 24 ++
 rtl/bra_predictor_gshare_if.sv | 32 +++
 rtl/bra_predictor_gshare_sat_counter.sv | 22 ++
 rtl/bra_predictor_gshare.sv | 100 ++++++++++
 tb/tb_bra_predictor_gshare.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/bra_predictor_gshare_pkg.sv
// Shared Bra_* constants and helpers for the gshare branch predictor slice.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package bra_predictor_gshare_pkg;

  localparam int Bra_Addr_Width  = 6;
  localparam int Bra_Hist_Width  = 4;
  localparam int Bra_Ctr_Width   = 2;

  // Index hash selectors
  localparam int Bra_Hash_Concat = 0;
  localparam int Bra_Hash_Xor    = 1;

  // Weakly-taken counter value: MSB set, all lower bits clear (2^(ctr_w-1)).
  function automatic int bra_weak_taken(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  // Table index width implied by the hash mode.
  function automatic int bra_idx_width(input int hist_w, input int addr_w, input int mode);
    return (mode == Bra_Hash_Concat) ? (hist_w + addr_w) : addr_w;
  endfunction

endpackage

// File: rtl/bra_predictor_gshare_if.sv
// Decoder lookup / ROB resolve bus of the gshare predictor.
// Latency: n/a (signal bundle).
// Backpressure: none; ready is the only status and it gates the whole predictor.
// Ports: ready, dec_valid/dec_addr/dec_prediction/dec_history (Decoder side),
//        brp_update/rob_addr/rob_history/rob_taken/rob_mispredict (ROB side).
interface bra_predictor_gshare_if #(
  parameter int ADDR_W = 6,
  parameter int HIST_W = 4
);
  logic              ready;
  logic              dec_valid;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_prediction;
  logic [HIST_W-1:0] dec_history;
  logic              brp_update;
  logic [ADDR_W-1:0] rob_addr;
  logic [HIST_W-1:0] rob_history;
  logic              rob_taken;
  logic              rob_mispredict;

  // Predictor side
  modport slave (
    output ready, dec_prediction, dec_history,
    input  dec_valid, dec_addr, brp_update, rob_addr, rob_history, rob_taken, rob_mispredict
  );

  // Decoder/ROB side
  modport master (
    input  ready, dec_prediction, dec_history,
    output dec_valid, dec_addr, brp_update, rob_addr, rob_history, rob_taken, rob_mispredict
  );
endinterface

// File: rtl/bra_predictor_gshare_sat_counter.sv
// Saturating up/down counter next-value: dir=1 counts up, dir=0 counts down.
// Latency: combinational.
// Backpressure: none.
// Ports: ctr (current value), dir (1 = up), ctr_next (saturated result).
module bra_sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             dir,
  output logic [CTR_W-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (dir) begin
      if (!(&ctr)) ctr_next = ctr + CTR_W'(1);
    end else begin
      if (|ctr) ctr_next = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/bra_predictor_gshare.sv
// Gshare branch predictor: counter table indexed by hash(global history, address).
// Latency: prediction combinational (0 cycles); training/history update visible next cycle.
// Backpressure: none; ready=0 during the post-reset table init walk, inputs ignored then.
// Ports: clk, rst (async, active-high), bus (slave modport of bra_predictor_gshare_if).
module bra_predictor_gshare
  import bra_predictor_gshare_pkg::*;
#(
  parameter int ADDR_W    = Bra_Addr_Width,
  parameter int HIST_W    = Bra_Hist_Width,
  parameter int CTR_W     = Bra_Ctr_Width,
  parameter int HASH_MODE = Bra_Hash_Concat
) (
  input logic                   clk,
  input logic                   rst,
  bra_predictor_gshare_if.slave bus
);

  localparam int              IDX_W      = bra_idx_width(HIST_W, ADDR_W, HASH_MODE);
  localparam int              DEPTH      = 1 << IDX_W;
  localparam logic [CTR_W-1:0] WEAK_TAKEN = CTR_W'(bra_weak_taken(CTR_W));

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic             ready_q;
  logic [HIST_W-1:0] spec_hist;
  logic [IDX_W-1:0] init_idx;

  logic [CTR_W-1:0] table_q [DEPTH];

  logic             run;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] idx_r;
  logic [CTR_W-1:0] ctr_r;
  logic [CTR_W-1:0] ctr_next;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_dat;
  logic             pred;

  function automatic logic [IDX_W-1:0] hash(input logic [HIST_W-1:0] h,
                                            input logic [ADDR_W-1:0] a);
    if (HASH_MODE == Bra_Hash_Concat) return IDX_W'({h, a});
    else                              return IDX_W'(a ^ ADDR_W'(h));
  endfunction

  assign run   = (state == ST_RUN);
  assign idx_d = hash(spec_hist, bus.dec_addr);
  assign idx_r = hash(bus.rob_history, bus.rob_addr);
  assign ctr_r = table_q[idx_r];

  // Lookup reads the array before this cycle's write lands (read-before-write).
  assign pred               = run & table_q[idx_d][CTR_W-1];
  assign bus.dec_prediction = pred;
  assign bus.dec_history    = run ? spec_hist : '0;
  assign bus.ready          = ready_q;

  bra_sat_counter #(.CTR_W(CTR_W)) u_sat (
    .ctr      (ctr_r),
    .dir      (bus.rob_taken),
    .ctr_next (ctr_next)
  );

  // Single write port shared by the init walk and ROB training.
  assign wr_en  = ~run | bus.brp_update;
  assign wr_idx = run ? idx_r : init_idx;
  assign wr_dat = run ? ctr_next : WEAK_TAKEN;

  always_ff @(posedge clk) begin
    if (wr_en) table_q[wr_idx] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      ready_q   <= 1'b0;
      spec_hist <= '0;
      init_idx  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + IDX_W'(1);
          if (&init_idx) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          // Repair restarts history from the resolved branch and wins over a shift.
          if (bus.brp_update && bus.rob_mispredict)
            spec_hist <= HIST_W'({bus.rob_history, bus.rob_taken});
          else if (bus.dec_valid)
            spec_hist <= HIST_W'({spec_hist, pred});
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bra_predictor_gshare.sv
// Directed bench for bra_predictor_gshare: concat-hash and xor-hash instances.
module tb_bra_predictor_gshare;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bra_predictor_gshare_if #(.ADDR_W(6), .HIST_W(4)) b0 ();
  bra_predictor_gshare_if #(.ADDR_W(6), .HIST_W(4)) bx ();

  bra_predictor_gshare #(.ADDR_W(6), .HIST_W(4), .CTR_W(2), .HASH_MODE(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  bra_predictor_gshare #(.ADDR_W(6), .HIST_W(4), .CTR_W(2), .HASH_MODE(1)) u_dut_x (
    .clk (clk),
    .rst (rst),
    .bus (bx)
  );

  typedef struct {
    logic       sel;   // 0 = concat instance, 1 = xor instance
    logic       dv;
    logic [5:0] da;
    logic       bu;
    logic [5:0] ra;
    logic [3:0] rh;
    logic       rt;
    logic       rm;
    logic       ep;
    logic [3:0] eh;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic sel, input logic dv, input logic [5:0] da,
                              input logic bu, input logic [5:0] ra, input logic [3:0] rh,
                              input logic rt, input logic rm, input logic ep,
                              input logic [3:0] eh);
    vec_t v;
    v.sel = sel; v.dv = dv; v.da = da; v.bu = bu; v.ra = ra;
    v.rh = rh; v.rt = rt; v.rm = rm; v.ep = ep; v.eh = eh;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic idle_all();
    b0.dec_valid = 1'b0; b0.dec_addr = '0; b0.brp_update = 1'b0; b0.rob_addr = '0;
    b0.rob_history = '0; b0.rob_taken = 1'b0; b0.rob_mispredict = 1'b0;
    bx.dec_valid = 1'b0; bx.dec_addr = '0; bx.brp_update = 1'b0; bx.rob_addr = '0;
    bx.rob_history = '0; bx.rob_taken = 1'b0; bx.rob_mispredict = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int n);
    @(negedge clk);
    idle_all();
    if (!v.sel) begin
      b0.dec_valid = v.dv; b0.dec_addr = v.da; b0.brp_update = v.bu; b0.rob_addr = v.ra;
      b0.rob_history = v.rh; b0.rob_taken = v.rt; b0.rob_mispredict = v.rm;
      #1;
      check($sformatf("vec%0d_pred", n), 32'(b0.dec_prediction), 32'(v.ep));
      check($sformatf("vec%0d_hist", n), 32'(b0.dec_history), 32'(v.eh));
    end else begin
      bx.dec_valid = v.dv; bx.dec_addr = v.da; bx.brp_update = v.bu; bx.rob_addr = v.ra;
      bx.rob_history = v.rh; bx.rob_taken = v.rt; bx.rob_mispredict = v.rm;
      #1;
      check($sformatf("vec%0d_xpred", n), 32'(bx.dec_prediction), 32'(v.ep));
      check($sformatf("vec%0d_xhist", n), 32'(bx.dec_history), 32'(v.eh));
    end
  endtask

  // Runs from just after rst release until b0.ready; dec_valid held on b0.
  task automatic wait_init(input string tag);
    int cnt;
    int cntx;
    int bad;
    cnt = 0; cntx = -1; bad = 0;
    #1;
    while (!b0.ready && cnt < 3000) begin
      if (b0.dec_prediction !== 1'b0 || b0.dec_history !== 4'b0000) bad++;
      if (bx.ready && cntx < 0) cntx = cnt;
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_walk_len"}, 32'(cnt), 32'd1024);
    check({tag, "_walk_len_xor"}, 32'(cntx), 32'd64);
    check({tag, "_outputs_quiet"}, 32'(bad), 32'd0);
  endtask

  initial begin
    idle_all();

    // Table of directed vectors, applied in order.
    // Saturation at {hist 0000, addr 5}: 10 -> 01 -> 00 -> 00 ... then up to 11.
    vecs.push_back(mk(0, 0, 6'd5, 1, 6'd5, 4'h0, 0, 0, 1, 4'h0));
    vecs.push_back(mk(0, 0, 6'd5, 1, 6'd5, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 6'd5, 1, 6'd5, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 6'd5, 1, 6'd5, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 6'd5, 0, 6'd0, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 6'd5, 1, 6'd5, 4'h0, 1, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 6'd5, 1, 6'd5, 4'h0, 1, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 6'd5, 1, 6'd5, 4'h0, 1, 0, 1, 4'h0));
    vecs.push_back(mk(0, 0, 6'd5, 1, 6'd5, 4'h0, 1, 0, 1, 4'h0));
    vecs.push_back(mk(0, 0, 6'd5, 1, 6'd5, 4'h0, 0, 0, 1, 4'h0));
    vecs.push_back(mk(0, 0, 6'd5, 0, 6'd0, 4'h0, 0, 0, 1, 4'h0));
    // Pre-train {0011, addr 3} to 01, then lookups predicting 1,1,0.
    vecs.push_back(mk(0, 0, 6'd3, 1, 6'd3, 4'b0011, 0, 0, 1, 4'h0));
    vecs.push_back(mk(0, 1, 6'd1, 0, 6'd0, 4'h0, 0, 0, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 6'd2, 0, 6'd0, 4'h0, 0, 0, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 6'd3, 0, 6'd0, 4'h0, 0, 0, 0, 4'b0011));
    vecs.push_back(mk(0, 0, 6'd0, 0, 6'd0, 4'h0, 0, 0, 1, 4'b0110));
    // Repair beats shift; lookup still uses pre-repair history.
    vecs.push_back(mk(0, 1, 6'd0, 1, 6'd7, 4'b1010, 1, 1, 1, 4'b0110));
    vecs.push_back(mk(0, 0, 6'd7, 0, 6'd0, 4'h0, 0, 0, 1, 4'b0101));
    vecs.push_back(mk(0, 0, 6'd0, 1, 6'd9, 4'b0011, 0, 1, 1, 4'b0101));
    vecs.push_back(mk(0, 0, 6'd0, 0, 6'd0, 4'h0, 0, 0, 1, 4'b0110));
    // Xor instance: addr 000011 ^ hist 0001 -> idx 000010, aliasing with addr 000010 / hist 0.
    vecs.push_back(mk(1, 1, 6'd0, 0, 6'd0, 4'h0, 0, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 0, 6'd3, 1, 6'd3, 4'b0001, 0, 0, 1, 4'b0001));
    vecs.push_back(mk(1, 0, 6'd3, 1, 6'd3, 4'b0001, 0, 0, 0, 4'b0001));
    vecs.push_back(mk(1, 0, 6'd3, 0, 6'd0, 4'h0, 0, 0, 0, 4'b0001));
    vecs.push_back(mk(1, 0, 6'd2, 1, 6'd63, 4'b0000, 0, 1, 1, 4'b0001));
    vecs.push_back(mk(1, 0, 6'd2, 0, 6'd0, 4'h0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 0, 6'd3, 0, 6'd0, 4'h0, 0, 0, 1, 4'b0000));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(b0.ready), 32'd0);
    check("reset_ready_xor", 32'(bx.ready), 32'd0);
    check("reset_pred", 32'(b0.dec_prediction), 32'd0);

    // Init walk with dec_valid held high on the concat instance
    @(negedge clk);
    rst = 1'b0;
    b0.dec_valid = 1'b1;
    wait_init("init");
    check("init_ready", 32'(b0.ready), 32'd1);

    // Every entry reachable at hist 0 reads weakly taken; dec_valid was ignored during init.
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      idle_all();
      b0.dec_addr = 6'(a);
      bx.dec_addr = 6'(a);
      #1;
      if (a == 0) check("init_hist_unshifted", 32'(b0.dec_history), 32'd0);
      check($sformatf("init_entry%0d", a), 32'(b0.dec_prediction), 32'd1);
      check($sformatf("init_xentry%0d", a), 32'(bx.dec_prediction), 32'd1);
    end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset mid-run with a pending mispredict update
    @(negedge clk);
    idle_all();
    b0.dec_valid = 1'b1; b0.brp_update = 1'b1; b0.rob_mispredict = 1'b1;
    b0.rob_history = 4'b1111; b0.rob_taken = 1'b1;
    #1;
    check("pre_rst_ready", 32'(b0.ready), 32'd1);
    check("pre_rst_hist", 32'(b0.dec_history), 32'b0110);
    #1 rst = 1'b1;
    #1;
    check("rst_async_ready", 32'(b0.ready), 32'd0);
    check("rst_async_ready_xor", 32'(bx.ready), 32'd0);
    check("rst_async_hist", 32'(b0.dec_history), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b0.brp_update = 1'b0; b0.rob_mispredict = 1'b0;
    wait_init("rerun");

    // Table re-initialised (xor idx 2 was trained to 00) and history restarted at 0
    @(negedge clk);
    idle_all();
    bx.dec_addr = 6'd2;
    #1;
    check("rerun_hist", 32'(b0.dec_history), 32'd0);
    check("rerun_xentry2", 32'(bx.dec_prediction), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
